// File: rtl/conv_window_gen_if.sv
// Pixel-in / window-out valid-ready bundle for conv_window_gen.
// Optional olast appears with CONV_WIN_LAST_EN.
interface conv_window_gen_if #(
  parameter int CH_NUM     = 6,
  parameter int DATA_WIDTH = 6,
  parameter int K          = 3
);
  localparam int PW = CH_NUM * DATA_WIDTH;

  logic            ivalid;
  logic            iready;
  logic [PW-1:0]   idata;
  logic            ovalid;
  logic            oready;
  logic [PW*K*K-1:0] dout;
`ifdef CONV_WIN_LAST_EN
  logic            olast;

  modport master (
    output ivalid, idata, oready,
    input  iready, ovalid, dout, olast
  );
  modport slave (
    input  ivalid, idata, oready,
    output iready, ovalid, dout, olast
  );
`else
  modport master (
    output ivalid, idata, oready,
    input  iready, ovalid, dout
  );
  modport slave (
    input  ivalid, idata, oready,
    output iready, ovalid, dout
  );
`endif
endinterface

// File: rtl/conv_window_gen.sv
// Streaming KxK sliding-window generator with stride and valid/ready.
// Define CONV_WIN_LAST_EN to add the registered olast flag.
module conv_window_gen #(
  parameter int CH_NUM     = 6,
  parameter int DATA_WIDTH = 6,
  parameter int K          = 3,
  parameter int IMG_W      = 9,
  parameter int IMG_H      = 9,
  parameter int STRIDE     = 1
) (
  input  logic clk,
  input  logic rstn,
  input  logic sclr,
  conv_window_gen_if.slave bus
);
  localparam int PW = CH_NUM * DATA_WIDTH;
  localparam int WW = PW * K * K;
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam int LR = K - 1 + ((IMG_H - K) / STRIDE) * STRIDE;
  localparam int LC = K - 1 + ((IMG_W - K) / STRIDE) * STRIDE;

  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic          ovalid_q, ovalid_d;
  logic [WW-1:0] dout_q, dout_d;
  logic [WW-1:0] win_flat;

  logic [PW-1:0] lb_q  [K-1][IMG_W];
  logic [PW-1:0] win_q [K][K];
  logic [PW-1:0] win_d [K][K];

  logic acc, emit, row_ok, col_ok;
  logic col_end, row_end;

  assign bus.iready = !ovalid_q || bus.oready;
  assign acc = bus.ivalid && bus.iready && !sclr;

  assign col_end = col_q == CW'(IMG_W - 1);
  assign row_end = row_q == RW'(IMG_H - 1);

  assign row_ok = (row_q >= RW'(K - 1)) &&
    ((row_q - RW'(K - 1)) % RW'(STRIDE) == '0);
  assign col_ok = (col_q >= CW'(K - 1)) &&
    ((col_q - CW'(K - 1)) % CW'(STRIDE) == '0);

  // Position gating is what keeps stale buffer rows out.
  assign emit = acc && row_ok && col_ok;

  always_comb begin
    win_flat = '0;
    for (int r = 0; r < K; r++) begin
      for (int c = 0; c < K - 1; c++) begin
        win_d[r][c] = win_q[r][c+1];
      end
    end
    for (int r = 0; r < K - 1; r++) begin
      win_d[r][K-1] = lb_q[r][col_q];
    end
    win_d[K-1][K-1] = bus.idata;
    for (int r = 0; r < K; r++) begin
      for (int c = 0; c < K; c++) begin
        win_flat[(r*K+c)*PW +: PW] = win_d[r][c];
      end
    end
  end

  always_comb begin
    col_d    = col_q;
    row_d    = row_q;
    ovalid_d = ovalid_q;
    dout_d   = dout_q;
    if (sclr) begin
      col_d    = '0;
      row_d    = '0;
      ovalid_d = 1'b0;
    end else begin
      if (acc) begin
        if (col_end) begin
          col_d = '0;
          row_d = row_end ? '0 : row_q + RW'(1);
        end else begin
          col_d = col_q + CW'(1);
        end
      end
      if (emit) begin
        ovalid_d = 1'b1;
        dout_d   = win_flat;
      end else if (bus.oready) begin
        ovalid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      col_q    <= '0;
      row_q    <= '0;
      ovalid_q <= 1'b0;
      dout_q   <= '0;
    end else begin
      col_q    <= col_d;
      row_q    <= row_d;
      ovalid_q <= ovalid_d;
      dout_q   <= dout_d;
    end
  end

  always_ff @(posedge clk) begin
    if (acc) begin
      for (int r = 0; r < K - 2; r++) begin
        lb_q[r][col_q] <= lb_q[r+1][col_q];
      end
      lb_q[K-2][col_q] <= bus.idata;
      win_q <= win_d;
    end
  end

  assign bus.ovalid = ovalid_q;
  assign bus.dout   = dout_q;

`ifdef CONV_WIN_LAST_EN
  logic olast_q, olast_d;

  always_comb begin
    olast_d = olast_q;
    if (sclr) begin
      olast_d = 1'b0;
    end else if (emit) begin
      olast_d = (row_q == RW'(LR)) &&
        (col_q == CW'(LC));
    end else if (bus.oready) begin
      olast_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) olast_q <= 1'b0;
    else       olast_q <= olast_d;
  end

  assign bus.olast = olast_q;
`endif
endmodule

// File: tb/tb_conv_window_gen.sv
// Directed bench: stride-1 and stride-2 instances on a 9x9 frame.
// Checks window sequences, stall hold, sclr and async reset.
module tb_conv_window_gen;
  localparam int WW = 324;
  localparam int P22 = 288;

  typedef struct {
    int stride;
    int gap;
    int stall;
    int n_exp;
    int f22;
    int l22;
  } vec_t;

  logic clk = 1'b0;
  logic rstn, sclr, dv, sel, ordy;
  logic [35:0] din;

  int n_cmp = 0;
  int n_bad = 0;
  int pcnt;
  int first_at;
  logic [WW-1:0] got[$];
  logic [WW-1:0] expq[$];
  logic lastq[$];

  conv_window_gen_if #(.CH_NUM(6), .DATA_WIDTH(6), .K(3)) ifa ();
  conv_window_gen_if #(.CH_NUM(6), .DATA_WIDTH(6), .K(3)) ifb ();

  assign ifa.ivalid = dv && !sel;
  assign ifb.ivalid = dv && sel;
  assign ifa.idata  = din;
  assign ifb.idata  = din;
  assign ifa.oready = ordy;
  assign ifb.oready = ordy;

  conv_window_gen #(.STRIDE(1)) u_s1 (
    .clk(clk), .rstn(rstn), .sclr(sclr), .bus(ifa)
  );
  conv_window_gen #(.STRIDE(2)) u_s2 (
    .clk(clk), .rstn(rstn), .sclr(sclr), .bus(ifb)
  );

  always #5 clk = ~clk;

  function automatic logic cur_ovalid();
    return sel ? ifb.ovalid : ifa.ovalid;
  endfunction

  function automatic logic cur_iready();
    return sel ? ifb.iready : ifa.iready;
  endfunction

  function automatic logic [WW-1:0] cur_dout();
    return sel ? ifb.dout : ifa.dout;
  endfunction

  always @(negedge clk) begin
    if (cur_ovalid() && ordy) begin
      got.push_back(cur_dout());
      if (got.size() == 1) first_at = pcnt;
`ifdef CONV_WIN_LAST_EN
      lastq.push_back(sel ? ifb.olast : ifa.olast);
`else
      lastq.push_back(1'b0);
`endif
    end
  end

  task automatic check(string nm, longint act, longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", nm, act, exp);
    end
  endtask

  function automatic logic [WW-1:0] exp_win(int row, int col);
    logic [WW-1:0] w;
    int v;
    w = '0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        for (int ch = 0; ch < 6; ch++) begin
          v = ((row - 2 + r) * 9 + (col - 2 + c) + 1) % 64;
          w[((r*3+c)*6+ch)*6 +: 6] = 6'(v);
        end
    return w;
  endfunction

  task automatic build_exp(int s);
    expq.delete();
    for (int row = 2; row < 9; row++)
      for (int col = 2; col < 9; col++)
        if ((row - 2) % s == 0 && (col - 2) % s == 0)
          expq.push_back(exp_win(row, col));
  endtask

  // Called at posedge+1; returns at posedge+1.
  task automatic put(int v, int gap);
    int t;
    logic r;
    din = {6{6'(v % 64)}};
    dv = 1'b1;
    t = 0;
    r = 1'b0;
    while (!r && t < 1000) begin
      @(negedge clk);
      r = cur_iready();
      t++;
    end
    if (!r) check("iready_timeout", 0, 1);
    @(posedge clk);
    if (r) pcnt++;
    #1;
    dv = 1'b0;
    repeat (gap - 1) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic stall_proc(int n);
    int t;
    logic [WW-1:0] held;
    t = 0;
    do begin
      @(posedge clk);
      #1;
      t++;
    end while (!cur_ovalid() && t < 2000);
    check("stall_wait", cur_ovalid(), 1);
    ordy = 1'b0;
    held = cur_dout();
    repeat (n) begin
      @(negedge clk);
      check("stall_iready", cur_iready(), 0);
      check("stall_hold", cur_dout() == held, 1);
    end
    @(posedge clk);
    #1;
    ordy = 1'b1;
  endtask

  task automatic run_case(vec_t t);
    int bad;
    sel = (t.stride == 2);
    got.delete();
    lastq.delete();
    first_at = -1;
    pcnt = 0;
    build_exp(t.stride);
    fork
      begin
        for (int i = 1; i <= 81; i++) put(i, t.gap);
      end
      begin
        if (t.stall > 0) stall_proc(t.stall);
      end
    join
    repeat (10) @(posedge clk);
    #1;
    check("count", got.size(), t.n_exp);
    bad = 0;
    for (int k = 0; k < got.size() && k < expq.size(); k++)
      if (got[k] !== expq[k]) bad++;
    check("seq", bad, 0);
    check("first_at", first_at, 21);
    if (got.size() > 0) begin
      check("first22", got[0][P22 +: 6], t.f22);
      check("last22", got[got.size()-1][P22 +: 6], t.l22);
    end
    if (t.stride == 2 && got.size() > 1)
      check("second22", got[1][P22 +: 6], 23);
`ifdef CONV_WIN_LAST_EN
    begin
      int nl;
      nl = 0;
      foreach (lastq[k]) nl += int'(lastq[k]);
      check("olast_cnt", nl, 1);
      if (lastq.size() > 0)
        check("olast_pos", lastq[lastq.size()-1], 1);
    end
`endif
    #100;
    @(posedge clk);
    #1;
  endtask

  vec_t tbl[5];

  initial begin
    tbl[0] = '{1, 1, 0, 49, 21, 17};
    tbl[1] = '{1, 4, 0, 49, 21, 17};
    tbl[2] = '{1, 4, 0, 49, 21, 17};
    tbl[3] = '{2, 1, 0, 16, 21, 17};
    tbl[4] = '{1, 1, 5, 49, 21, 17};

    rstn = 1'b0;
    sclr = 1'b0;
    dv   = 1'b0;
    sel  = 1'b0;
    ordy = 1'b1;
    din  = '0;
    pcnt = 0;
    first_at = -1;
    #12;
    check("rst_ovalid_a", ifa.ovalid, 0);
    check("rst_ovalid_b", ifb.ovalid, 0);
    check("rst_dout", ifa.dout === '0, 1);
    check("rst_iready", ifa.iready, 1);
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 5; i++) run_case(tbl[i]);

    // sclr on pixel 40 drops it and restarts the frame.
    sel = 1'b0;
    got.delete();
    pcnt = 0;
    for (int i = 1; i <= 39; i++) put(i, 1);
    din  = {6{6'd40}};
    dv   = 1'b1;
    sclr = 1'b1;
    @(posedge clk);
    #1;
    sclr = 1'b0;
    dv   = 1'b0;
    @(negedge clk);
    check("sclr_ovalid", ifa.ovalid, 0);
    check("sclr_count", got.size(), 15);
    @(posedge clk);
    #1;
    run_case(tbl[0]);

    // Async reset while a window is pending.
    sel  = 1'b0;
    ordy = 1'b0;
    got.delete();
    pcnt = 0;
    for (int i = 1; i <= 21; i++) put(i, 1);
    check("prerst_ovalid", ifa.ovalid, 1);
    #2;
    rstn = 1'b0;
    #1;
    check("arst_ovalid", ifa.ovalid, 0);
    check("arst_dout", ifa.dout === '0, 1);
    check("arst_iready", ifa.iready, 1);
`ifdef CONV_WIN_LAST_EN
    check("arst_olast", ifa.olast, 0);
`endif
    @(negedge clk);
    rstn = 1'b1;
    ordy = 1'b1;
    @(posedge clk);
    #1;
    run_case(tbl[0]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/conv_window_gen.md
# conv_window_gen

Streaming K×K sliding-window generator for the BNN convolution datapath, successor to the fixed conv_slide block. It accepts one multi-channel pixel per handshake in raster order, buffers K-1 image rows internally, and emits each complete K×K×CH_NUM window to the downstream binary-conv PE array. Compared with the previous generation, it adds image height, configurable stride, valid/ready backpressure on both sides, automatic frame wrap, and a synchronous frame clear.

## Interface
- CH_NUM, 6: channels per pixel
- DATA_WIDTH, 6: bits per channel sample
- K, 3: window size (K ≥ 2)
- IMG_W, 9: image width in pixels (IMG_W ≥ K)
- IMG_H, 9: image height in pixels (IMG_H ≥ K)
- STRIDE, 1: window step in both directions (1 ≤ STRIDE ≤ K)

- clk  in  1  single clock, rising edge
- rstn  in  1  asynchronous active-low reset
- sclr  in  1  synchronous frame clear
- ivalid  in  1  input pixel valid
- iready  out  1  block can accept a pixel
- idata  in  CH_NUM*DATA_WIDTH  pixel; channel ch at [ch*DATA_WIDTH +: DATA_WIDTH]
- ovalid  out  1  window valid
- oready  in  1  downstream accepts the window
- dout  out  CH_NUM*K*K*DATA_WIDTH  window; element (r,c) channel ch at [((r*K+c)*CH_NUM+ch)*DATA_WIDTH +: DATA_WIDTH]. r=0 is the oldest (top) row and c=0 is the leftmost (oldest) column.
- olast  out  1  last window of frame (only with CONV_WIN_LAST_EN)

## Operation
- A pixel is accepted when ivalid && iready. Only accepted pixels advance the state.
- Counters col (0..IMG_W-1) and row (0..IMG_H-1) hold the position of the next pixel.
- On accept: the pixel is written to the line buffer and to the window shift register. col increments. At IMG_W-1, col wraps to 0 and row increments. At (IMG_H-1, IMG_W-1), both wrap to 0, and the next accepted pixel starts a new frame with no bubble.
- Line buffer: K-1 rows × IMG_W pixels. Window column c=K-1 is {buffered rows, current pixel}. Columns shift left on each accept.
- A window is emitted for an accepted pixel at (row, col) only when all of these hold:
  - row ≥ K-1
  - col ≥ K-1
  - (row-(K-1)) % STRIDE == 0
  - (col-(K-1)) % STRIDE == 0
- Windows never straddle a row boundary or a frame boundary. Stale buffer data from a previous frame is never emitted.
- Windows per frame: ((IMG_H-K)/STRIDE+1) × ((IMG_W-K)/STRIDE+1), using floor division.
- Output stage is a single register. iready = !ovalid || oready. This is combinational and contains no path from ivalid.
- While ovalid && !oready: dout, ovalid, and olast are held stable, and no pixel is accepted.
- sclr has priority over an accept in the same cycle. It zeros row, col, ovalid, and olast, and drops any pending window. Line buffer contents are not cleared.

## Timing
- Reset (rstn low, asynchronous): ovalid=0, dout=0, olast=0, row=col=0, iready=1.
- Line buffer and window registers need no reset. Gating prevents them from being emitted before they are refilled.
- Latency: ovalid rises on the clock edge that accepts the window-completing pixel, so dout is visible in the next cycle.
- When an output handshake and a new window occur in the same cycle, ovalid stays 1 and dout updates. This gives full throughput: 1 pixel/cycle with oready tied high.
- When an output handshake occurs with no new window, ovalid falls to 0 on that edge.
- If rstn is asserted mid-frame, the frame restarts at (0,0) after release.

## Configuration
- CONV_WIN_LAST_EN defined:
  - Adds the olast port and a registered flag.
  - olast=1 together with ovalid for the window ending at pixel (IMG_H-1, IMG_W-1) when that pixel meets the stride condition, otherwise for the last emitted window of the frame.
  - olast follows the same hold rule as dout.
- CONV_WIN_LAST_EN undefined: the port and the logic are absent. Behaviour is otherwise identical.

## Test plan
- Defaults, values i=1..81 raster (all channels equal i mod 64), oready=1, ivalid every cycle:
  - exactly 49 windows are emitted;
  - the first window follows pixel 21, with (0,0)=1, (1,1)=11, (2,2)=21;
  - the last window has (2,2)=81 mod 64=17 and olast=1.
- Same stimulus, ivalid 1 in 4 cycles, repeated for a second frame after a 100 ns gap: both frames give identical 49-window sequences. No window appears from pixels 1..20 of frame 2.
- STRIDE=2:
  - 16 windows, at centre positions (row,col) ∈ {1,3,5,7}²;
  - the first has (2,2)=21, the second (2,2)=23;
  - none is emitted on rows 3, 5, or 7 (odd rows).
- Backpressure: hold oready=0 for 5 cycles after the first ovalid.
  - iready=0 during the stall, dout stable, no pixel lost;
  - after release, the window sequence matches the no-stall run.
- sclr pulsed at pixel 40 together with ivalid: the pixel is dropped and ovalid=0 next cycle. Re-streaming 1..81 yields 49 correct windows.
- rstn pulled low mid-window with ovalid=1: ovalid, dout, and olast are 0 immediately. After release, a full frame produces 49 correct windows.
